// File: rtl/wbgpio_pkg.sv
// Shared Wishbone GPIO definitions: bus widths and register address map.
package wbgpio_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 3;
  localparam int unsigned ARM_CNT_W = 3;

  typedef logic [WB_AW-1:0] wb_addr_t;

  localparam wb_addr_t ADR_OUT  = 3'd0;
  localparam wb_addr_t ADR_IN   = 3'd1;
  localparam wb_addr_t ADR_RISE = 3'd2;
  localparam wb_addr_t ADR_FALL = 3'd3;
  localparam wb_addr_t ADR_PEND = 3'd4;

  // Masked update: bits selected by mask take the new value, others hold.
  function automatic logic [15:0] mask_merge(input logic [15:0] cur,
                                             input logic [15:0] val,
                                             input logic [15:0] mask);
    return (cur & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain bringing asynchronous input pins into the i_clk domain.
module gpio_sync #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NSYNC = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage [NSYNC];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NSYNC); i++) stage[i] <= '0;
    end else begin
      stage[0] <= i_d;
      for (int i = 1; i < int'(NSYNC); i++) stage[i] <= stage[i-1];
    end
  end

  assign o_q = stage[NSYNC-1];

endmodule

// File: rtl/wbgpio_edge.sv
// Wishbone GPIO block with masked output writes and edge-triggered, W1C interrupt pending bits.
module wbgpio_edge
  import wbgpio_pkg::*;
#(
  parameter int unsigned      NIN     = 16,
  parameter int unsigned      NOUT    = 16,
  parameter logic [NOUT-1:0]  DEFAULT = '0,
  parameter int unsigned      NSYNC   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [WB_AW-1:0] i_wb_addr,
  input  logic [WB_DW-1:0] i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [WB_DW-1:0] o_wb_data,
  input  logic [NIN-1:0]   i_gpio,
  output logic [NOUT-1:0]  o_gpio,
  output logic             o_int
);

  logic                 stb_c;
  logic                 wr_c;
  logic [NIN-1:0]       sync;
  logic [NIN-1:0]       prev;
  logic [NIN-1:0]       rise_en;
  logic [NIN-1:0]       fall_en;
  logic [NIN-1:0]       pend;
  logic [NIN-1:0]       set_c;
  logic [NIN-1:0]       w1c_c;
  logic [NIN-1:0]       pend_nxt_c;
  logic [NOUT-1:0]      out_nxt_c;
  logic [15:0]          out_merge_c;
  logic [ARM_CNT_W-1:0] arm_cnt;
  logic                 armed;
  logic [WB_DW-1:0]     rd_data_c;
  logic                 unused_c;

  assign o_wb_stall = 1'b0;
  assign stb_c      = i_wb_cyc & i_wb_stb;
  assign wr_c       = stb_c & i_wb_we;
  assign unused_c   = ^{i_wb_sel, i_wb_data};

  gpio_sync #(
    .WIDTH (NIN),
    .NSYNC (NSYNC)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_gpio),
    .o_q     (sync)
  );

  // Next-state for pending bits: a new edge wins over a same-cycle clear.
  always_comb begin
    set_c = '0;
    w1c_c = '0;
    if (armed) set_c = ((sync & ~prev) & rise_en) | ((~sync & prev) & fall_en);
    if (wr_c && (i_wb_addr == ADR_PEND)) w1c_c = i_wb_data[NIN-1:0];
    pend_nxt_c = (pend & ~w1c_c) | set_c;
  end

  assign out_merge_c = mask_merge(16'(o_gpio), 16'(i_wb_data[NOUT-1:0]),
                                  16'(i_wb_data[NOUT+15:16]));
  assign out_nxt_c   = out_merge_c[NOUT-1:0];

  // Read mux sees register state ahead of any write in the same cycle.
  always_comb begin
    rd_data_c = '0;
    case (i_wb_addr)
      ADR_OUT:  rd_data_c = WB_DW'(o_gpio);
      ADR_IN:   rd_data_c = WB_DW'(sync);
      ADR_RISE: rd_data_c = WB_DW'(rise_en);
      ADR_FALL: rd_data_c = WB_DW'(fall_en);
      ADR_PEND: rd_data_c = WB_DW'(pend);
      default:  rd_data_c = '0;
    endcase
  end

  // Bus side: ack/data, output pins and edge enables.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_gpio    <= DEFAULT;
      rise_en   <= '0;
      fall_en   <= '0;
    end else begin
      o_wb_ack <= stb_c;
      if (stb_c) o_wb_data <= rd_data_c;
      if (wr_c) begin
        case (i_wb_addr)
          ADR_OUT:  o_gpio  <= out_nxt_c;
          ADR_RISE: rise_en <= i_wb_data[NIN-1:0];
          ADR_FALL: fall_en <= i_wb_data[NIN-1:0];
          default:  ;
        endcase
      end
    end
  end

  // Edge detector: arming holds off until the sync chain and prev have filled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev    <= '0;
      pend    <= '0;
      o_int   <= 1'b0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      prev  <= sync;
      pend  <= pend_nxt_c;
      o_int <= |pend;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARM_CNT_W'(1);
        if (arm_cnt == ARM_CNT_W'(NSYNC)) armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wbgpio_edge.sv
// Directed self-checking bench for wbgpio_edge with default 16/16 pins and NSYNC=2.
module tb_wbgpio_edge;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [2:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_stall, o_wb_ack;
  logic [31:0] o_wb_data;
  logic [15:0] i_gpio;
  logic [15:0] o_gpio;
  logic        o_int;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  badr [6];
  logic [31:0] bexp [6];

  always #5 i_clk = ~i_clk;

  wbgpio_edge #(
    .NIN     (16),
    .NOUT    (16),
    .DEFAULT (16'h0000),
    .NSYNC   (2)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_wb_sel   (i_wb_sel),
    .o_wb_stall (o_wb_stall),
    .o_wb_ack   (o_wb_ack),
    .o_wb_data  (o_wb_data),
    .i_gpio     (i_gpio),
    .o_gpio     (o_gpio),
    .o_int      (o_int)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [31:0] d);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = adr; i_wb_data = d;
    @(posedge i_clk);
    #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    check("write_ack", 32'(o_wb_ack), 32'd1);
  endtask

  task automatic wb_read(input logic [2:0] adr, input string tag, input logic [31:0] exp);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
    i_wb_addr = adr; i_wb_data = 32'h0;
    @(posedge i_clk);
    #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    check({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
    check(tag, o_wb_data, exp);
  endtask

  initial begin
    i_reset = 1'b1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = 3'd0; i_wb_data = 32'h0; i_wb_sel = 4'hF;
    i_gpio = 16'h0001;

    // Reset state
    idle(2);
    check("rst_gpio", 32'(o_gpio), 32'h0);
    check("rst_ack", 32'(o_wb_ack), 32'h0);
    check("rst_data", o_wb_data, 32'h0);
    check("rst_int", 32'(o_int), 32'h0);
    check("rst_stall", 32'(o_wb_stall), 32'h0);

    // Arm window: held pin high with RISE enabled must not set PEND
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    wb_write(3'd2, 32'h0000_0001);
    idle(3);
    wb_read(3'd4, "arm_pend", 32'h0);
    check("arm_int", 32'(o_int), 32'h0);

    // Masked output writes
    wb_write(3'd0, 32'h0003_0001);
    check("out_1", 32'(o_gpio), 32'h0001);
    wb_write(3'd0, 32'h0002_0002);
    check("out_2", 32'(o_gpio), 32'h0003);
    wb_write(3'd0, 32'h0001_0000);
    check("out_3", 32'(o_gpio), 32'h0002);
    wb_read(3'd0, "rd_out", 32'h0000_0002);

    i_gpio = 16'hA5A1;
    idle(3);
    wb_read(3'd1, "rd_in", 32'h0000_A5A1);
    wb_read(3'd2, "rd_rise", 32'h0000_0001);

    // Rising edge on pin 2; o_int lags PEND by one cycle
    wb_write(3'd2, 32'h0000_0004);
    i_gpio = 16'hA5A5;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      #1;
      check("rise_int_low", 32'(o_int), 32'h0);
    end
    @(posedge i_clk);
    #1;
    check("rise_int_high", 32'(o_int), 32'h1);
    wb_read(3'd4, "rise_pend", 32'h0000_0004);
    wb_write(3'd4, 32'h0000_0004);
    wb_read(3'd4, "w1c_pend", 32'h0);
    check("w1c_int", 32'(o_int), 32'h0);

    // Falling edge with FALL disabled sets nothing
    i_gpio = 16'hA5A1;
    idle(4);
    wb_read(3'd4, "fall_off_pend", 32'h0);

    // Falling edge on pin 8; disabling FALL keeps the pending bit
    wb_write(3'd3, 32'h0000_0100);
    i_gpio = 16'hA4A1;
    idle(4);
    wb_read(3'd4, "fall_pend", 32'h0000_0100);
    wb_write(3'd3, 32'h0000_0000);
    wb_read(3'd4, "fall_keep", 32'h0000_0100);

    // Same-cycle W1C and new edge on pin 2; pin 8 still clears
    i_gpio = 16'hA4A5;
    idle(4);
    wb_read(3'd4, "pre_race", 32'h0000_0104);
    i_gpio = 16'hA4A1;
    idle(4);
    i_gpio = 16'hA4A5;
    idle(2);
    wb_write(3'd4, 32'h0000_0104);
    wb_read(3'd4, "race_pend", 32'h0000_0004);
    check("race_int", 32'(o_int), 32'h1);
    wb_write(3'd4, 32'h0000_0004);
    wb_read(3'd4, "clr_pend", 32'h0);

    // Back-to-back reads, including unmapped address and masked upper bits
    wb_write(3'd7, 32'hFFFF_FFFF);
    wb_write(3'd2, 32'hFFFF_0004);
    wb_write(3'd3, 32'h0000_0300);
    badr[0] = 3'd0; bexp[0] = 32'h0000_0002;
    badr[1] = 3'd1; bexp[1] = 32'h0000_A4A5;
    badr[2] = 3'd2; bexp[2] = 32'h0000_0004;
    badr[3] = 3'd3; bexp[3] = 32'h0000_0300;
    badr[4] = 3'd4; bexp[4] = 32'h0000_0000;
    badr[5] = 3'd7; bexp[5] = 32'h0000_0000;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = badr[0];
    for (int i = 1; i <= 6; i++) begin
      @(posedge i_clk);
      #1;
      check("burst_ack", 32'(o_wb_ack), 32'h1);
      check("burst_data", o_wb_data, bexp[i-1]);
      if (i < 6) i_wb_addr = badr[i];
      else begin
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      end
    end
    idle(1);
    check("burst_end_ack", 32'(o_wb_ack), 32'h0);

    // Reset during a pending strobe drops the ack and clears outputs
    i_gpio = 16'hA4A1;
    idle(4);
    i_gpio = 16'hA4A5;
    idle(5);
    check("pre_rst_int", 32'(o_int), 32'h1);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = 3'd0; i_wb_data = 32'hFFFF_FFFF;
    #4;
    i_reset = 1'b1;
    #1;
    check("mid_rst_gpio", 32'(o_gpio), 32'h0);
    check("mid_rst_int", 32'(o_int), 32'h0);
    check("mid_rst_ack", 32'(o_wb_ack), 32'h0);
    @(posedge i_clk);
    #1;
    check("mid_rst_ack2", 32'(o_wb_ack), 32'h0);
    check("mid_rst_gpio2", 32'(o_gpio), 32'h0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_reset = 1'b0;
    idle(1);
    check("post_rst_ack", 32'(o_wb_ack), 32'h0);
    wb_read(3'd2, "post_rst_rise", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbgpio_edge.md
WBGPIO_EDGE -- requirements
Module: wbgpio_edge

Interface
REQ-001 SHALL have parameter NIN, default 16: input pin count, 1..32.
REQ-002 SHALL have parameter NOUT, default 16: output pin count, 1..16.
REQ-003 SHALL have parameter DEFAULT, default 0, NOUT bits: o_gpio reset value.
REQ-004 SHALL have parameter NSYNC, default 2: input synchroniser depth, 2..4.
REQ-005 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined control.
REQ-008 SHALL have port i_wb_addr  in  3  register select.
REQ-009 SHALL have port i_wb_data  in  32  write data.
REQ-010 SHALL have port i_wb_sel  in  4  byte enables; ignored.
REQ-011 SHALL have port o_wb_stall  out  1  tied 0.
REQ-012 SHALL have port o_wb_ack  out  1  registered acknowledge.
REQ-013 SHALL have port o_wb_data  out  32  registered read data.
REQ-014 SHALL have port i_gpio  in  NIN  asynchronous input pins.
REQ-015 SHALL have port o_gpio  out  NOUT  output pins, registered.
REQ-016 SHALL have port o_int  out  1  level interrupt, registered.

Function
REQ-017 Register map, bits above NIN/NOUT read 0: 0 OUT, 1 IN (synchronised, read-only), 2 RISE (rw), 3 FALL (rw), 4 PEND (W1C); 5-7 read 0, writes ignored.
REQ-018 OUT write: o_gpio <= (o_gpio & ~d[NOUT+15:16]) | (d[NOUT-1:0] & d[NOUT+15:16]); unmasked bits hold.
REQ-019 Every accepted strobe (i_wb_stb, cyc-qualified) SHALL assert o_wb_ack exactly one cycle later with o_wb_data valid that cycle; back-to-back strobes ack every cycle.
REQ-020 Read data SHALL reflect register state before any write accepted in the same cycle.
REQ-021 i_gpio SHALL pass an NSYNC-stage flop chain; a last-stage copy forms prev; rise = sync & ~prev, fall = ~sync & prev.
REQ-022 PEND[i] SHALL set when (rise[i]&RISE[i]) | (fall[i]&FALL[i]) and edge detect is armed.
REQ-023 Simultaneous edge set and W1C on the same bit SHALL leave PEND set; W1C of other bits unaffected.
REQ-024 Clearing RISE/FALL SHALL NOT clear already-pending PEND bits.
REQ-025 o_int SHALL equal registered |PEND, one cycle after PEND changes.
REQ-026 Arming: after reset release a counter SHALL hold edge detect disarmed for NSYNC+1 cycles, then arm permanently until next reset.
REQ-027 An edge of width >= 1 clock SHALL be captured; sub-clock glitches need not be.

Reset
REQ-028 On i_reset, asynchronously: o_gpio=DEFAULT, RISE=FALL=PEND=0, sync chain and prev=0, arm counter=0 (disarmed), o_wb_ack=0, o_wb_data=0, o_int=0.
REQ-029 Reset asserted mid-transaction SHALL drop the pending ack; no ack for that strobe.

Structure
REQ-030 Register address constants (ADR_OUT..ADR_PEND) SHALL live in shared package wbgpio_pkg.
REQ-031 Synchroniser SHALL be sub-module gpio_sync (parameters WIDTH, NSYNC, async reset).

Verification
REQ-032 Reset release, i_gpio=0x0001 held, RISE=0x0001 -> no PEND during arm window; PEND=0 after.
REQ-033 Write 0x00030001 to OUT from 0x0000 -> o_gpio=0x0001; then 0x00020002 -> 0x0003; then 0x00010000 -> 0x0002.
REQ-034 RISE=0x0004, pin 2 0->1 -> PEND=0x0004 within NSYNC+1 cycles, o_int=1 next cycle; falling edge sets nothing.
REQ-035 Write PEND=0x0004 same cycle new rising edge reaches detector -> PEND stays 0x0004, o_int stays 1.
REQ-036 Back-to-back reads addr 0,1,2,3,4,7 -> six consecutive acks, addr 7 returns 0x00000000.
REQ-037 Assert i_reset cycle after a strobe -> no ack, o_gpio=DEFAULT, o_int=0 immediately.
